debug_dump_engine: RTL

- Downstream observer of the single-cycle computer's debug ports.
- On a software start pulse or a PC breakpoint match, it snapshots fetchPC, then sweeps debug_reg_select over x0..x(NUM_REGS-1) and captures each debug_reg_out value.
- Emits the result as a valid/ready word stream (one PC header, then one word per register) toward a UART/trace sink.
- No clock gating of the computer: the dump is not atomic while the CPU runs; software parks the CPU (e.g. self-loop) for a coherent dump.

---
 rtl/debug_dump_engine_pkg.sv | 13 +
 rtl/debug_dump_engine_bp_edge_detect.sv | 30 +++
 rtl/debug_dump_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/debug_dump_engine_pkg.sv
// Shared constants for the debug dump engine: FSM encoding, stream tags, default widths.
package debug_dump_engine_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    localparam logic [5:0] TAG_PC = 6'h20;

endpackage

// File: rtl/debug_dump_engine_bp_edge_detect.sv
// PC breakpoint comparator with rising-edge detection so a CPU parked on bp_pc fires once.
module bp_edge_detect
    import debug_dump_engine_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_pc,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            bp_rise
);

    logic bp_hit;
    logic bp_prev_q;
    logic bp_prev_d;

    always_comb begin
        bp_hit    = bp_en && (fetch_pc == bp_pc);
        bp_prev_d = bp_hit;
        bp_rise   = bp_hit && !bp_prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bp_prev_q <= 1'b0;
        else       bp_prev_q <= bp_prev_d;
    end

endmodule

// File: rtl/debug_dump_engine.sv
// Snapshots fetchPC and sweeps the computer's debug register port, streaming a PC header
// followed by one word per register over a valid/ready interface.
module debug_dump_engine
    import debug_dump_engine_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bp_en,
    input  logic [XLEN-1:0]  bp_pc,
    input  logic [XLEN-1:0]  fetchPC,
    output logic [SEL_W-1:0] debug_reg_select,
    input  logic [XLEN-1:0]  debug_reg_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [XLEN-1:0]  m_data,
    output logic [5:0]       m_tag,
    output logic             m_last,
    output logic             busy,
    output logic [7:0]       dump_count
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    logic [1:0]       state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             m_valid_q, m_valid_d;
    logic [XLEN-1:0]  m_data_q, m_data_d;
    logic [5:0]       m_tag_q, m_tag_d;
    logic             m_last_q, m_last_d;
    logic             busy_q, busy_d;
    logic [7:0]       dump_count_q, dump_count_d;
    logic             bp_rise;
    logic             trigger;

    bp_edge_detect #(.XLEN(XLEN)) u_bp_edge (
        .clk      (clk),
        .reset    (reset),
        .bp_en    (bp_en),
        .bp_pc    (bp_pc),
        .fetch_pc (fetchPC),
        .bp_rise  (bp_rise)
    );

    always_comb begin
        trigger      = start || bp_rise;
        state_d      = state_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_tag_d      = m_tag_q;
        m_last_d     = m_last_q;
        dump_count_d = dump_count_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    m_data_d  = fetchPC;
                    m_tag_d   = TAG_PC;
                    m_last_d  = 1'b0;
                    m_valid_d = 1'b1;
                    idx_d     = 5'd0;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    sel_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // select was updated on the previous edge, so debug_reg_out is settled here
                m_data_d  = debug_reg_out;
                m_tag_d   = {1'b0, idx_q};
                m_last_d  = (idx_q == LAST_IDX);
                m_valid_d = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d     = 1'b0;
                        sel_d        = '0;
                        dump_count_d = dump_count_q + 8'd1;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        sel_d   = SEL_W'(idx_q + 5'd1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sel_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_tag_q      <= '0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            dump_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_tag_q      <= m_tag_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            dump_count_q <= dump_count_d;
        end
    end

    assign debug_reg_select = sel_q;
    assign m_valid          = m_valid_q;
    assign m_data           = m_data_q;
    assign m_tag            = m_tag_q;
    assign m_last           = m_last_q;
    assign busy             = busy_q;
    assign dump_count       = dump_count_q;

endmodule
